// File: rtl/regfile_arb_pkg.sv
// Shared widths and types for the register-file write arbiter.
// Builds with REGFILE_ARB_STARVE_GUARD_EN see the same package; nothing in it is guard-specific.
package regfile_arb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   // Register index that the register file hard-wires to zero.
   localparam logic [DEF_ADDR_W-1:0] R0 = '0;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] waddr;
      logic [DEF_DATA_W-1:0] data;
   } rf_wr_t;

endpackage

// File: rtl/regarb_fifo.sv
// Small FIFO of pending mul/div register writes.
// Each entry has a live bit so that a younger WB write can cancel it while it waits.
module regarb_fifo
   import regfile_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int Q_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [ADDR_W-1:0]          push_addr,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   input  logic                       kill_en,
   input  logic [ADDR_W-1:0]          kill_addr,
   output logic [ADDR_W-1:0]          head_addr,
   output logic [DATA_W-1:0]          head_data,
   output logic                       head_valid,
   output logic [$clog2(Q_DEPTH):0]   count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(Q_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0]  addr_q [Q_DEPTH];
   logic [DATA_W-1:0]  data_q [Q_DEPTH];
   logic [Q_DEPTH-1:0] vld_q;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;

   // Payload storage carries no reset; the live bits and count guard it.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= push_addr;
         data_q[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld_q  <= '0;
      end else begin
         if (kill_en) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
               if (addr_q[i] == kill_addr) vld_q[i] <= 1'b0;
            end
         end
         // A push always lands in a free slot, so it may overwrite a kill of that slot.
         if (push) begin
            vld_q[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_addr  = addr_q[rd_ptr];
   assign head_data  = data_q[rd_ptr];
   assign head_valid = vld_q[rd_ptr];
   assign full       = (count == CW'(Q_DEPTH));
   assign empty      = (count == '0);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB (fixed priority) and queued mul/div results.
// Define REGFILE_ARB_STARVE_GUARD_EN to add the starvation counter that drives stall_req.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
`ifdef REGFILE_ARB_STARVE_GUARD_EN
   parameter int STARVE_MAX = 4,
`endif
   parameter int Q_DEPTH    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wb_valid,
   input  logic [ADDR_W-1:0]         wb_reg,
   input  logic [DATA_W-1:0]         wb_data,
   input  logic                      md_valid,
   output logic                      md_ready,
   input  logic [ADDR_W-1:0]         md_reg,
   input  logic [DATA_W-1:0]         md_data,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   output logic [$clog2(Q_DEPTH):0]  q_count,
   output logic                      stall_req
);

   localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(R0);

   logic              wb_grant;
   logic              q_grant;
   logic              head_live;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              head_valid;

   // A queued r0 write or a killed entry leaves the queue without using the port,
   // so it pops even while WB owns the slot.
   assign wb_grant  = wb_valid && (wb_reg != REG_ZERO);
   assign head_live = head_valid && (head_addr != REG_ZERO);
   assign q_grant   = !empty && !wb_grant && head_live;
   assign pop       = !empty && (!wb_grant || !head_live);
   assign md_ready  = !full;
   assign push      = md_valid && md_ready;

   regarb_fifo #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .Q_DEPTH (Q_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_addr  (md_reg),
      .push_data  (md_data),
      .pop        (pop),
      .kill_en    (wb_grant),
      .kill_addr  (wb_reg),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .head_valid (head_valid),
      .count      (q_count),
      .full       (full),
      .empty      (empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= wb_grant || q_grant;
         if (wb_grant) begin
            rf_waddr <= wb_reg;
            rf_wdata <= wb_data;
         end else if (q_grant) begin
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
         end
      end
   end

`ifdef REGFILE_ARB_STARVE_GUARD_EN
   localparam int WW = $clog2(STARVE_MAX + 1);

   logic [WW-1:0] wait_cnt;
   logic [WW-1:0] wait_nxt;

   // Any non-empty cycle without a pop means WB took the slot; saturate at the limit.
   always_comb begin
      wait_nxt = wait_cnt;
      if (pop)
         wait_nxt = '0;
      else if (!empty && (wait_cnt != WW'(STARVE_MAX)))
         wait_nxt = wait_cnt + WW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt  <= '0;
         stall_req <= 1'b0;
      end else begin
         wait_cnt  <= wait_nxt;
         stall_req <= !pop && (wait_nxt == WW'(STARVE_MAX));
      end
   end
`else
   assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with the default parameters.
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic [31:0] wb_data = '0;
   logic        md_valid = 1'b0;
   logic        md_ready;
   logic [4:0]  md_reg = '0;
   logic [31:0] md_data = '0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [1:0]  q_count;
   logic        stall_req;

   int n_cmp = 0;
   int n_err = 0;

   regfile_write_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .wb_valid  (wb_valid),
      .wb_reg    (wb_reg),
      .wb_data   (wb_data),
      .md_valid  (md_valid),
      .md_ready  (md_ready),
      .md_reg    (md_reg),
      .md_data   (md_data),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .q_count   (q_count),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wb(input logic v, input logic [4:0] r, input logic [31:0] d);
      wb_valid = v;
      wb_reg   = r;
      wb_data  = d;
   endtask

   task automatic set_md(input logic v, input logic [4:0] r, input logic [31:0] d);
      md_valid = v;
      md_reg   = r;
      md_data  = d;
   endtask

   initial begin
      // Reset held with random traffic
      for (int i = 0; i < 4; i++) begin
         wb_valid = 1'($urandom_range(0, 1));
         wb_reg   = 5'($urandom);
         wb_data  = $urandom;
         md_valid = 1'($urandom_range(0, 1));
         md_reg   = 5'($urandom);
         md_data  = $urandom;
         cyc();
         chk("rst_we", rf_we, 0);
         chk("rst_ready", md_ready, 1);
         chk("rst_count", q_count, 0);
         chk("rst_stall", stall_req, 0);
      end
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      set_wb(0, 0, 0);
      set_md(0, 0, 0);
      #3 rst = 1'b1;
      cyc();
      chk("post_rst_we", rf_we, 0);
      chk("post_rst_count", q_count, 0);

      // Priority: WB wins, mul/div result follows one cycle later
      set_wb(1, 5'd3, 32'h11);
      set_md(1, 5'd4, 32'h22);
      cyc();
      chk("prio_we1", rf_we, 1);
      chk("prio_addr1", rf_waddr, 3);
      chk("prio_data1", rf_wdata, 32'h11);
      chk("prio_count1", q_count, 1);
      set_wb(0, 0, 0);
      set_md(0, 0, 0);
      cyc();
      chk("prio_we2", rf_we, 1);
      chk("prio_addr2", rf_waddr, 4);
      chk("prio_data2", rf_wdata, 32'h22);
      chk("prio_count2", q_count, 0);
      cyc();
      chk("prio_idle", rf_we, 0);

      // Full queue while WB keeps the port busy
      set_wb(1, 5'd5, 32'h55);
      set_md(1, 5'd6, 32'h61);
      chk("full_ready0", md_ready, 1);
      cyc();
      chk("full_count1", q_count, 1);
      chk("full_ready1", md_ready, 1);
      set_md(1, 5'd8, 32'h62);
      cyc();
      chk("full_count2", q_count, 2);
      chk("full_ready2", md_ready, 0);
      set_md(1, 5'd9, 32'h63);
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("full_held_count", q_count, 2);
         chk("full_wb_addr", rf_waddr, 5);
         chk("full_wb_data", rf_wdata, 32'h55);
      end
      set_wb(0, 0, 0);
      cyc();
      chk("drain_we1", rf_we, 1);
      chk("drain_addr1", rf_waddr, 6);
      chk("drain_data1", rf_wdata, 32'h61);
      chk("drain_count1", q_count, 1);
      chk("drain_ready1", md_ready, 1);
      cyc();
      chk("drain_addr2", rf_waddr, 8);
      chk("drain_data2", rf_wdata, 32'h62);
      chk("drain_count2", q_count, 1);
      set_md(0, 0, 0);
      cyc();
      chk("drain_addr3", rf_waddr, 9);
      chk("drain_data3", rf_wdata, 32'h63);
      chk("drain_count3", q_count, 0);
      cyc();
      chk("drain_idle", rf_we, 0);

      // WAW kill: younger WB to r7 cancels the queued r7 result
      set_md(1, 5'd7, 32'hAA);
      cyc();
      chk("waw_count1", q_count, 1);
      chk("waw_we0", rf_we, 0);
      set_md(0, 0, 0);
      set_wb(1, 5'd7, 32'hBB);
      cyc();
      chk("waw_we1", rf_we, 1);
      chk("waw_addr1", rf_waddr, 7);
      chk("waw_data1", rf_wdata, 32'hBB);
      set_wb(0, 0, 0);
      cyc();
      chk("waw_we2", rf_we, 0);
      chk("waw_count2", q_count, 0);
      cyc();
      chk("waw_we3", rf_we, 0);

      // Same-cycle push and WB to the same register: the push survives
      set_wb(1, 5'd10, 32'h1);
      set_md(1, 5'd10, 32'h2);
      cyc();
      chk("same_addr1", rf_waddr, 10);
      chk("same_data1", rf_wdata, 32'h1);
      set_wb(0, 0, 0);
      set_md(0, 0, 0);
      cyc();
      chk("same_we2", rf_we, 1);
      chk("same_data2", rf_wdata, 32'h2);
      chk("same_count2", q_count, 0);

      // r0 writes never reach the port
      set_md(1, 5'd0, 32'h5);
      set_wb(1, 5'd0, 32'h6);
      cyc();
      chk("r0_we1", rf_we, 0);
      chk("r0_count1", q_count, 1);
      set_wb(0, 0, 0);
      set_md(0, 0, 0);
      cyc();
      chk("r0_we2", rf_we, 0);
      chk("r0_count2", q_count, 0);

      // Starvation: one entry waits behind continuous WB
      set_wb(1, 5'd5, 32'h55);
      set_md(1, 5'd12, 32'hC);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         set_md(0, 0, 0);
         chk("starve_count", q_count, 1);
         chk("starve_we", rf_we, 1);
         chk("starve_stall", stall_req, 32'(GUARD && (i == 5)));
      end
      set_wb(0, 0, 0);
      cyc();
      chk("starve_pop_addr", rf_waddr, 12);
      chk("starve_pop_data", rf_wdata, 32'hC);
      chk("starve_pop_count", q_count, 0);
      chk("starve_pop_stall", stall_req, 0);

      // Reset in the middle of a drain discards the queue
      set_wb(1, 5'd5, 32'h55);
      set_md(1, 5'd13, 32'hD);
      cyc();
      set_md(1, 5'd14, 32'hE);
      cyc();
      chk("mid_count", q_count, 2);
      set_md(0, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_count", q_count, 0);
      chk("mid_rst_ready", md_ready, 1);
      chk("mid_rst_we", rf_we, 0);
      set_wb(0, 0, 0);
      #2 rst = 1'b1;
      cyc();
      cyc();
      chk("mid_after_we", rf_we, 0);
      chk("mid_after_count", q_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
